// File: rtl/wm_phase_ctrl.sv
// Washing machine job sequencer: IDLE -> PRE -> WASH -> BILL (or REJECT).
// Owns the customer balance, the price table and the sticky fine flag.
module wm_phase_ctrl #(
    parameter logic [8:0]         DY_PRICE  = 9'd2,
    parameter logic [8:0]         S_PRICE   = 9'd3,
    parameter logic [8:0]         M_PRICE   = 9'd5,
    parameter logic [8:0]         B_PRICE   = 9'd8,
    parameter logic [8:0]         FINE_AMT  = 9'd5,
    parameter logic signed [10:0] INIT_BAL  = 11'sd100,
    parameter logic [8:0]         TOPUP_AMT = 9'd10,
    parameter logic [26:0]        REJ_CYC   = 27'd100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_pos,
    input  logic               topup_pos,
    input  logic               pre_done,
    input  logic [1:0]         pre_mode,
    input  logic               wash_done,
    input  logic               fine_req,
    input  logic               bill_done,
    output logic               pre_en,
    output logic               wash_start,
    output logic [2:0]         wash_mode,
    output logic               bill_start,
    output logic signed [10:0] bill_amt,
    output logic signed [10:0] bal,
    output logic [1:0]         disp_sel,
    output logic [7:0]         state_led
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WASH = 3'd2,
        ST_BILL = 3'd3,
        ST_REJ  = 3'd4
    } state_t;

    state_t              r_state, w_state;
    logic                r_fine, w_fine;
    logic                r_neg, w_neg;
    logic [8:0]          r_price, w_price;
    logic [26:0]         r_rej_cnt, w_cnt;
    logic signed [10:0]  w_bal, w_amt;
    logic [2:0]          w_mode;
    logic                w_ws, w_bs;
    logic [8:0]          w_tbl;
    logic                w_fine_any;
    logic signed [10:0]  w_bamt;
    logic signed [11:0]  w_up, w_dn;
    logic signed [10:0]  w_up_sat, w_dn_sat;
    logic                w_refused;

    // Status LEDs: one-hot state, fine mirror, refused-while-negative flag.
    function automatic logic [7:0] f_led(input state_t st, input logic fine,
                                         input logic neg);
        case (st)
            ST_IDLE: f_led = {neg, fine, 6'b000001};
            ST_PRE:  f_led = {neg, fine, 6'b000010};
            ST_WASH: f_led = {neg, fine, 6'b000100};
            ST_BILL: f_led = {neg, fine, 6'b001000};
            ST_REJ:  f_led = 8'hFF;
            default: f_led = 8'h01;
        endcase
    endfunction

    function automatic logic [1:0] f_disp(input state_t st);
        case (st)
            ST_PRE:  f_disp = 2'b01;
            ST_WASH: f_disp = 2'b10;
            ST_BILL: f_disp = 2'b11;
            default: f_disp = 2'b00;
        endcase
    endfunction

    // Price lookup for the program being confirmed.
    always_comb begin
        w_tbl = B_PRICE;
        unique case (pre_mode)
            2'b00: w_tbl = DY_PRICE;
            2'b01: w_tbl = S_PRICE;
            2'b10: w_tbl = M_PRICE;
            2'b11: w_tbl = B_PRICE;
        endcase
    end

    assign w_fine_any = r_fine | fine_req;
    assign w_bamt     = $signed({2'b00, r_price}) +
                        (w_fine_any ? $signed({2'b00, FINE_AMT}) : 11'sd0);
    assign w_up       = {r_bal_ext(bal)} + $signed({3'b000, TOPUP_AMT});
    assign w_dn       = {r_bal_ext(bal)} - {w_bamt[10], w_bamt};
    assign w_up_sat   = (w_up > 12'sd1023) ? 11'sd1023 : w_up[10:0];
    assign w_dn_sat   = (w_dn < -12'sd1024) ? -11'sd1024 : w_dn[10:0];
    assign w_refused  = m_pos & bal[10];

    function automatic logic [11:0] r_bal_ext(input logic [10:0] b);
        r_bal_ext = {b[10], b};
    endfunction

    // Next-state and next-value decode for one job phase.
    always_comb begin
        w_state = r_state;
        w_bal   = bal;
        w_fine  = r_fine;
        w_neg   = r_neg;
        w_price = r_price;
        w_mode  = wash_mode;
        w_amt   = bill_amt;
        w_ws    = 1'b0;
        w_bs    = 1'b0;
        w_cnt   = r_rej_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (topup_pos) w_bal = w_up_sat;
                if (m_pos && !bal[10]) w_state = ST_PRE;
                w_neg = w_bal[10] & (r_neg | w_refused);
            end
            ST_PRE: begin
                if (pre_done) begin
                    w_mode  = {1'b0, pre_mode};
                    w_price = w_tbl;
                    if (bal >= $signed({2'b00, w_tbl})) begin
                        w_state = ST_WASH;
                        w_ws    = 1'b1;
                    end else begin
                        w_state = ST_REJ;
                        w_cnt   = 27'd0;
                    end
                end
            end
            ST_WASH: begin
                w_fine = w_fine_any;
                if (wash_done) begin
                    w_amt   = w_bamt;
                    w_bal   = w_dn_sat;
                    w_bs    = 1'b1;
                    w_state = ST_BILL;
                end
            end
            ST_BILL: begin
                if (bill_done) begin
                    w_fine  = 1'b0;
                    w_state = ST_IDLE;
                end
            end
            ST_REJ: begin
                if (r_rej_cnt == REJ_CYC - 27'd1) begin
                    w_cnt   = 27'd0;
                    w_state = ST_IDLE;
                end else begin
                    w_cnt = r_rej_cnt + 27'd1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // Register state and every output from the decoded next values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_fine     <= 1'b0;
            r_neg      <= 1'b0;
            r_price    <= 9'd0;
            r_rej_cnt  <= 27'd0;
            pre_en     <= 1'b0;
            wash_start <= 1'b0;
            wash_mode  <= 3'd0;
            bill_start <= 1'b0;
            bill_amt   <= 11'sd0;
            bal        <= INIT_BAL;
            disp_sel   <= 2'b00;
            state_led  <= 8'h01;
        end else begin
            r_state    <= w_state;
            r_fine     <= w_fine;
            r_neg      <= w_neg;
            r_price    <= w_price;
            r_rej_cnt  <= w_cnt;
            pre_en     <= (w_state == ST_PRE);
            wash_start <= w_ws;
            wash_mode  <= w_mode;
            bill_start <= w_bs;
            bill_amt   <= w_amt;
            bal        <= w_bal;
            disp_sel   <= f_disp(w_state);
            state_led  <= f_led(w_state, w_fine, w_neg);
        end
    end

endmodule

// File: tb/tb_wm_phase_ctrl.sv
// Bench for wm_phase_ctrl: directed job scenarios plus random pulses,
// every cycle compared against a job-level reference model.
module tb_wm_phase_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               m_pos = 1'b0;
    logic               topup_pos = 1'b0;
    logic               pre_done = 1'b0;
    logic [1:0]         pre_mode = 2'b00;
    logic               wash_done = 1'b0;
    logic               fine_req = 1'b0;
    logic               bill_done = 1'b0;
    logic               pre_en;
    logic               wash_start;
    logic [2:0]         wash_mode;
    logic               bill_start;
    logic signed [10:0] bill_amt;
    logic signed [10:0] bal;
    logic [1:0]         disp_sel;
    logic [7:0]         state_led;

    int checks = 0;
    int failures = 0;

    localparam int REJ = 8;
    localparam int P_IDLE = 0, P_PRE = 1, P_WASH = 2, P_BILL = 3, P_REJ = 4;

    wm_phase_ctrl #(.REJ_CYC(27'd8)) dut (
        .clk(clk), .rst(rst), .m_pos(m_pos), .topup_pos(topup_pos),
        .pre_done(pre_done), .pre_mode(pre_mode), .wash_done(wash_done),
        .fine_req(fine_req), .bill_done(bill_done), .pre_en(pre_en),
        .wash_start(wash_start), .wash_mode(wash_mode),
        .bill_start(bill_start), .bill_amt(bill_amt), .bal(bal),
        .disp_sel(disp_sel), .state_led(state_led)
    );

    always #5 clk = ~clk;

    // reference model of the job
    int price_tbl [4] = '{2, 3, 5, 8};
    int ph, mbal, mprice, mmode, mamt, mleft;
    bit mfine, mneg, mws, mbs;

    task automatic model_reset();
        ph = P_IDLE; mbal = 100; mprice = 0; mmode = 0; mamt = 0;
        mleft = 0; mfine = 0; mneg = 0; mws = 0; mbs = 0;
    endtask

    task automatic model_edge(input bit m, t, pd, input int pm,
                              input bit wd, fr, bd);
        bit refused;
        mws = 0;
        mbs = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        case (ph)
            P_IDLE: begin
                refused = m && (mbal < 0);
                if (m && mbal >= 0) ph = P_PRE;
                if (t) mbal = (mbal + 10 > 1023) ? 1023 : mbal + 10;
                mneg = (mbal < 0) && (mneg || refused);
            end
            P_PRE: if (pd) begin
                mmode = pm;
                mprice = price_tbl[pm];
                if (mbal >= mprice) begin
                    ph = P_WASH;
                    mws = 1;
                end else begin
                    ph = P_REJ;
                    mleft = REJ;
                end
            end
            P_WASH: begin
                if (fr) mfine = 1;
                if (wd) begin
                    mamt = mprice + (mfine ? 5 : 0);
                    mbal = (mbal - mamt < -1024) ? -1024 : mbal - mamt;
                    mbs = 1;
                    ph = P_BILL;
                end
            end
            P_BILL: if (bd) begin
                mfine = 0;
                ph = P_IDLE;
            end
            default: begin
                mleft--;
                if (mleft == 0) ph = P_IDLE;
            end
        endcase
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int eled;
        eled = (ph == P_REJ) ? 255 :
               ((1 << ph) | (int'(mfine) << 6) | (int'(mneg) << 7));
        chk("pre_en", int'(pre_en), int'(ph == P_PRE));
        chk("wash_start", int'(wash_start), int'(mws));
        chk("wash_mode", int'(wash_mode), mmode);
        chk("bill_start", int'(bill_start), int'(mbs));
        chk("bill_amt", int'(bill_amt), mamt);
        chk("bal", int'(bal), mbal);
        chk("disp_sel", int'(disp_sel), (ph == P_REJ) ? 0 : ph);
        chk("state_led", int'(state_led), eled);
    endtask

    task automatic step(input bit m, t, pd, input int pm,
                        input bit wd, fr, bd);
        m_pos = m; topup_pos = t; pre_done = pd;
        pre_mode = 2'(pm); wash_done = wd; fine_req = fr; bill_done = bd;
        @(posedge clk);
        model_edge(m, t, pd, pm, wd, fr, bd);
        #1;
        check_all();
        m_pos = 0; topup_pos = 0; pre_done = 0;
        wash_done = 0; fine_req = 0; bill_done = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic job(input int md, input int nf);
        step(1, 0, 0, md, 0, 0, 0);
        idle();
        step(0, 0, 1, md, 0, 0, 0);
        if (ph == P_REJ) begin
            repeat (REJ + 1) idle();
            return;
        end
        idle();
        for (int i = 0; i < nf - 1; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, nf > 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1);
        idle();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        chk("rst_bal", int'(bal), 100);
        chk("rst_led", int'(state_led), 1);
        @(negedge clk);
        rst = 1;

        // plain medium job
        step(1, 0, 0, 0, 0, 0, 0);
        chk("pre_en_on", int'(pre_en), 1);
        idle();
        step(0, 0, 1, 2, 0, 0, 0);
        chk("ws_pulse", int'(wash_start), 1);
        chk("wmode", int'(wash_mode), 2);
        idle();
        chk("ws_once", int'(wash_start), 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("bill5", int'(bill_amt), 5);
        chk("bal95", int'(bal), 95);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("back_idle", int'(state_led), 1);

        // small job with three fines, the last with wash_done
        job(1, 3);
        chk("bill8", int'(bill_amt), 8);
        chk("bal87", int'(bal), 87);
        chk("fine_clr", int'(state_led[6]), 0);

        // drain to 3
        for (int i = 0; i < 6; i++) job(3, 1);
        for (int i = 0; i < 3; i++) job(0, 0);
        chk("bal3", int'(bal), 3);

        // big program not affordable -> REJECT
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        chk("rej_led", int'(state_led), 255);
        chk("rej_disp", int'(disp_sel), 0);
        repeat (REJ - 1) idle();
        chk("rej_hold", int'(state_led), 255);
        idle();
        chk("rej_exit", int'(state_led), 1);
        chk("rej_bal", int'(bal), 3);

        // fine drives the balance negative
        job(1, 1);
        chk("bal_neg", int'(bal), -5);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("refused", int'(pre_en), 0);
        chk("led7", int'(state_led[7]), 1);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("topup5", int'(bal), 5);
        chk("led7_clr", int'(state_led[7]), 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("accepted", int'(pre_en), 1);
        step(0, 0, 1, 0, 0, 0, 0);
        idle();

        // asynchronous abort mid-WASH
        #2 rst = 0;
        #1 model_reset();
        check_all();
        chk("abort_bal", int'(bal), 100);
        chk("abort_led", int'(state_led), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        #2 rst = 1;
        step(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_pre", int'(pre_en), 1);
        step(0, 0, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("bal90", int'(bal), 90);

        // saturating top-up coincident with start
        repeat (93) step(0, 1, 0, 0, 0, 0, 0);
        chk("bal1020", int'(bal), 1020);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("sat1023", int'(bal), 1023);
        chk("sat_pre", int'(pre_en), 1);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("pre_no_topup", int'(bal), 1023);
        step(0, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // random pulses
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(7) == 0, $urandom_range(9) == 0,
                 $urandom_range(5) == 0, int'($urandom_range(3)),
                 $urandom_range(7) == 0, $urandom_range(9) == 0,
                 $urandom_range(4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
